// File: rtl/reg_writeback_buffer_if.sv
// Writeback request, register-file write port and bypass lookup bundle
// for the register writeback buffer.
interface reg_writeback_buffer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              drain_en;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              byp_hit1;
    logic [DATA_W-1:0] byp_data1;
    logic              byp_hit2;
    logic [DATA_W-1:0] byp_data2;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;

    modport master (
        output wb_valid, wb_rd, wb_data, drain_en, rd_addr1, rd_addr2,
        input  wb_ready, reg_write, write_reg, write_data,
        input  byp_hit1, byp_data1, byp_hit2, byp_data2,
        input  count, full, empty
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, drain_en, rd_addr1, rd_addr2,
        output wb_ready, reg_write, write_reg, write_data,
        output byp_hit1, byp_data1, byp_hit2, byp_data2,
        output count, full, empty
    );
endinterface

// File: rtl/reg_writeback_buffer.sv
// Writeback FIFO feeding the register file write port, with
// youngest-match bypass over queued entries and the output stage.
module reg_writeback_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input logic                  clk,
    input logic                  rst,
    reg_writeback_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] rd_mem_q  [DEPTH];
    logic [DATA_W-1:0] dat_mem_q [DEPTH];

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    logic full, empty, push, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // Ready is not pop-aware: a full buffer refuses even while draining.
    assign push  = bus.wb_valid && !full;
    assign pop   = bus.drain_en && !empty;

    always_comb begin
        wr_ptr_d     = wr_ptr_q + PW'(push);
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        count_d      = count_q + CW'(push) - CW'(pop);
        reg_write_d  = pop;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (pop) begin
            write_reg_d  = rd_mem_q[rd_ptr_q];
            write_data_d = dat_mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]  <= bus.wb_rd;
            dat_mem_q[wr_ptr_q] <= bus.wb_data;
        end
    end

    logic [ADDR_W-1:0] look_addr [2];
    logic              look_hit  [2];
    logic [DATA_W-1:0] look_data [2];

    assign look_addr[0] = bus.rd_addr1;
    assign look_addr[1] = bus.rd_addr2;

    // Scan oldest to youngest so the newest match overwrites older ones;
    // the output stage is older than anything still queued.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            look_hit[p]  = 1'b0;
            look_data[p] = '0;
            if (reg_write_q && write_reg_q == look_addr[p]) begin
                look_hit[p]  = 1'b1;
                look_data[p] = write_data_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) < count_q &&
                    rd_mem_q[rd_ptr_q + PW'(i)] == look_addr[p]) begin
                    look_hit[p]  = 1'b1;
                    look_data[p] = dat_mem_q[rd_ptr_q + PW'(i)];
                end
            end
        end
    end

    assign bus.wb_ready   = !full;
    assign bus.reg_write  = reg_write_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;
    assign bus.byp_hit1   = look_hit[0];
    assign bus.byp_data1  = look_data[0];
    assign bus.byp_hit2   = look_hit[1];
    assign bus.byp_data2  = look_data[1];
    assign bus.count      = count_q;
    assign bus.full       = full;
    assign bus.empty      = empty;
endmodule

// File: tb/tb_reg_writeback_buffer.sv
// Directed bench: stimulus queues expected writes, a negedge monitor
// checks every register-file write against that queue in order.
module tb_reg_writeback_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    reg_writeback_buffer_if #(.DATA_W(16), .ADDR_W(4), .DEPTH(4)) bus ();

    reg_writeback_buffer #(.DATA_W(16), .ADDR_W(4), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int nwrites = 0;
    int acc_cnt = 0;
    logic [19:0] exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [3:0] rd, input logic [15:0] d);
        logic rdy;
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_data  = d;
        for (int n = 0; n <= 50; n++) begin
            if (n == 50) begin
                chk("push_timeout", 0, 1);
                break;
            end
            rdy = bus.wb_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                exp_q.push_back({rd, d});
                acc_cnt++;
                break;
            end
        end
        bus.wb_valid = 1'b0;
    endtask

    task automatic drain_all();
        bus.drain_en = 1'b1;
        for (int n = 0; n < 20 && !bus.empty; n++) step();
        chk("drain_empty", 32'(bus.empty), 1);
        bus.drain_en = 1'b0;
        step();
        step();
    endtask

    always @(negedge clk) begin
        if (!rst && bus.reg_write) begin
            logic [19:0] e;
            nwrites++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(bus.write_reg), 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_reg", 32'(bus.write_reg), 32'(e[19:16]));
                chk("wr_data", 32'(bus.write_data), 32'(e[15:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        int base;
        bus.wb_valid = 1'b0;
        bus.wb_rd    = '0;
        bus.wb_data  = '0;
        bus.drain_en = 1'b0;
        bus.rd_addr1 = '0;
        bus.rd_addr2 = '0;

        #12;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_ready", 32'(bus.wb_ready), 1);
        chk("rst_regwrite", 32'(bus.reg_write), 0);
        rst = 1'b0;
        step();

        // mid-stream reset with three queued and one in the output stage
        for (int k = 0; k < 4; k++) push(4'(k + 1), 16'h0C00 + 16'(k));
        bus.drain_en = 1'b1;
        step();
        bus.drain_en = 1'b0;
        chk("pre_rst_count", 32'(bus.count), 3);
        chk("pre_rst_regwrite", 32'(bus.reg_write), 1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(bus.count), 0);
        chk("arst_regwrite", 32'(bus.reg_write), 0);
        chk("arst_empty", 32'(bus.empty), 1);
        chk("arst_write_reg", 32'(bus.write_reg), 0);
        exp_q.delete();
        step();
        rst = 1'b0;
        step();

        // single write latency
        bus.drain_en = 1'b1;
        push(4'd5, 16'hBEEF);
        chk("t2_count", 32'(bus.count), 1);
        chk("t2_regwrite0", 32'(bus.reg_write), 0);
        step();
        chk("t2_regwrite1", 32'(bus.reg_write), 1);
        chk("t2_write_reg", 32'(bus.write_reg), 5);
        chk("t2_write_data", 32'(bus.write_data), 32'hBEEF);
        chk("t2_empty", 32'(bus.empty), 1);
        bus.drain_en = 1'b0;
        step();
        chk("t2_regwrite_drop", 32'(bus.reg_write), 0);
        chk("t2_hold_data", 32'(bus.write_data), 32'hBEEF);

        // fill and hold the fifth request
        wr0 = nwrites;
        for (int k = 0; k < 4; k++) push(4'(k + 1), 16'hA001 + 16'(k));
        chk("t3_full", 32'(bus.full), 1);
        chk("t3_ready", 32'(bus.wb_ready), 0);
        chk("t3_count", 32'(bus.count), 4);
        base = acc_cnt;
        fork
            push(4'd5, 16'hA005);
        join_none
        step();
        step();
        chk("t3_held_acc", acc_cnt, base);
        chk("t3_held_count", 32'(bus.count), 4);
        bus.drain_en = 1'b1;
        step();
        chk("t3_pop1_count", 32'(bus.count), 3);
        chk("t3_pop1_acc", acc_cnt, base);
        step();
        chk("t3_accept5", acc_cnt, base + 1);
        chk("t3_count_pp", 32'(bus.count), 3);
        drain_all();
        chk("t3_writes", nwrites - wr0, 5);

        // bypass youngest-match ordering
        push(4'd3, 16'h1111);
        push(4'd3, 16'h2222);
        bus.rd_addr1 = 4'd3;
        bus.rd_addr2 = 4'd4;
        #1;
        chk("t4_hit1", 32'(bus.byp_hit1), 1);
        chk("t4_data1", 32'(bus.byp_data1), 32'h2222);
        chk("t4_hit2", 32'(bus.byp_hit2), 0);
        chk("t4_data2", 32'(bus.byp_data2), 0);
        bus.drain_en = 1'b1;
        step();
        chk("t4_mix_hit1", 32'(bus.byp_hit1), 1);
        chk("t4_mix_data1", 32'(bus.byp_data1), 32'h2222);
        step();
        chk("t4_out_hit1", 32'(bus.byp_hit1), 1);
        chk("t4_out_data1", 32'(bus.byp_data1), 32'h2222);
        bus.drain_en = 1'b0;
        step();
        chk("t4_gone_hit1", 32'(bus.byp_hit1), 0);
        chk("t4_gone_data1", 32'(bus.byp_data1), 0);

        // concurrent push/pop at count 2 across pointer wrap
        push(4'd7, 16'h5000);
        push(4'd8, 16'h5001);
        bus.drain_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(4'(i), 16'h5100 + 16'(i));
            chk("t5_count", 32'(bus.count), 2);
        end
        drain_all();

        // drain gating
        for (int k = 0; k < 4; k++) push(4'(k + 9), 16'h6000 + 16'(k));
        wr0 = nwrites;
        for (int i = 0; i < 8; i++) begin
            bus.drain_en = (i % 2 == 0);
            step();
            chk("t6_pulse", 32'(bus.reg_write), 32'(i % 2 == 0));
        end
        bus.drain_en = 1'b0;
        step();
        chk("t6_empty", 32'(bus.empty), 1);
        chk("t6_writes", nwrites - wr0, 4);

        step();
        chk("sb_leftover", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
